chunked_subtractor: RTL and testbench

Multi-cycle unsigned subtractor computing `d = a - b - bin` with borrow-out, processing `CHUNK` bits per clock from LSB to MSB. It is the inverse-direction companion to the adder family. The handshaked registered wrapper lets area-constrained paths trade latency for a narrow carry chain. It sits between a valid/ready producer and consumer, and its registered outputs are timing-clean for synthesis comparison against the parallel adders.

---
 rtl/chunked_subtractor.sv | 129 ++++++++++++
 tb/tb_chunked_subtractor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// chunked_subtractor
//   Multi-cycle unsigned subtractor: {bout, d} = a - b - bin, computed CHUNK
//   bits per clock from LSB to MSB through a narrow CHUNK+1 bit borrow chain.
//   The operation is accepted on a valid/ready input handshake. The result is
//   held until a valid/ready output handshake takes it. Operations never overlap.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid  i   operands a, b, bin valid
//   in_ready  o   IDLE, able to accept an operation
//   a, b      i   WIDTH-bit unsigned minuend / subtrahend
//   bin       i   borrow-in
//   out_valid o   d / bout hold a completed result (DONE)
//   out_ready i   consumer takes the result
//   d         o   (a - b - bin) mod 2^WIDTH
//   bout      o   borrow-out, 1 iff a < b + bin
module chunked_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);
  localparam int NSTEP = WIDTH / CHUNK;
  localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int CW    = CHUNK + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [KW-1:0]    k_q, k_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CW-1:0]    sub;
  logic             last_step;

  // Chunk select as a compare-mux over k, so no variable part-select is needed.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < NSTEP; i++) begin
      if (k_q == KW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // The top bit of the CHUNK+1 bit result is set exactly when the chunk wraps.
  assign sub       = {1'b0, a_ch} - {1'b0, b_ch} - CW'(borrow_q);
  assign last_step = (k_q == KW'(NSTEP - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    k_d      = k_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          k_d      = '0;
          d_d      = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int i = 0; i < NSTEP; i++) begin
          if (k_q == KW'(i)) d_d[i*CHUNK +: CHUNK] = sub[CHUNK-1:0];
        end
        borrow_d = sub[CHUNK];
        // k holds on the last step so it never wraps inside an operation.
        if (last_step) begin
          bout_d  = sub[CHUNK];
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      k_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      k_q      <= k_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  // All outputs are decodes of registered state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Testbench for chunked_subtractor: directed vectors on a CHUNK=8 instance,
// plus random operations with output stalls on CHUNK=1 and CHUNK=32 instances.
module tb_chunked_subtractor;
  localparam int OPS = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [31:0] a, b, d;
  int          nvec = 0;
  int          nmis = 0;
  logic [1:0]  aux_done = '0;

  always #5 clk = ~clk;

  chunked_subtractor #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the CHUNK=8 instance; hold>0 keeps out_ready low for
  // that many cycles after out_valid while the input pins are scrambled.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input logic [31:0] ed, input logic eb, input int hold);
    int   cyc;
    logic rdy_seen, stable;
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = (hold == 0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0; rdy_seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(4));
    chk({tag, "_busy_rdy"}, 64'(rdy_seen | in_ready), 64'(0));
    chk({tag, "_d"}, 64'(d), 64'(ed));
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        a = $urandom; b = $urandom; bin = ~bin; in_valid = ~in_valid;
        @(posedge clk); #1;
        stable &= (d == ed) && (bout == eb) && out_valid && !in_ready;
      end
      in_valid = 1'b0;
      chk({tag, "_hold_stable"}, 64'(stable), 64'(1));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_post_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_post_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_d_bout", {31'd0, bout, d}, 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("basic",     32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 0);
    run_op("under1",    32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("under_bin", 32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("xchunk",    32'h0100_0000,  32'h0000_0001,  1'b0, 32'h00FF_FFFF, 1'b0, 0);
    run_op("all_ones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("bp",        32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 32'h7777_7788, 1'b1, 10);

    // Reset two steps into BUSY: the low chunk of d is already written.
    a = 32'd7; b = 32'd2; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_d", 64'(d), 64'(0));
    chk("midrst_bout", 64'(bout), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 0);

    t = 0;
    while (aux_done != 2'b11 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("aux_finished", 64'(aux_done), 64'(3));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Random operations with output stalls at CHUNK=1 and CHUNK=32.
  for (genvar g = 0; g < 2; g++) begin : g_aux
    localparam int CH = (g == 0) ? 1 : 32;
    localparam int NS = 32 / CH;
    logic        x_rst, x_iv, x_ir, x_bin, x_ov, x_or, x_bout;
    logic [31:0] x_a, x_b, x_d;

    chunked_subtractor #(.WIDTH(32), .CHUNK(CH)) u_aux (
      .clk(clk), .rst(x_rst), .in_valid(x_iv), .in_ready(x_ir),
      .a(x_a), .b(x_b), .bin(x_bin), .out_valid(x_ov), .out_ready(x_or),
      .d(x_d), .bout(x_bout)
    );

    initial begin
      string tg;
      logic [32:0] exp;
      int   cyc;
      logic took;
      tg = (CH == 1) ? "c1" : "c32";
      x_rst = 1'b1; x_iv = 1'b0; x_or = 1'b0; x_a = '0; x_b = '0; x_bin = 1'b0;
      @(posedge clk); #1;
      x_rst = 1'b0;
      for (int n = 0; n < OPS; n++) begin
        x_a = $urandom; x_b = $urandom; x_bin = 1'($urandom_range(0, 1));
        if (n == 0) begin x_a = 32'd0; x_b = 32'hFFFF_FFFF; x_bin = 1'b1; end
        exp = {1'b0, x_a} - {1'b0, x_b} - 33'(x_bin);
        x_iv = 1'b1; x_or = 1'b0;
        @(posedge clk); #1;
        x_iv = 1'b0;
        x_a = $urandom; x_b = $urandom;
        cyc = 0;
        while (!x_ov && cyc < 100) begin
          @(posedge clk); #1;
          cyc++;
        end
        chk({tg, "_latency"}, 64'(cyc), 64'(NS));
        chk({tg, "_result"}, 64'({x_bout, x_d}), 64'(exp));
        took = 1'b0; cyc = 0;
        while (!took && cyc < 50) begin
          x_or = 1'($urandom_range(0, 1));
          took = x_or;
          @(posedge clk); #1;
          cyc++;
        end
        x_or = 1'b0;
        chk({tg, "_handshake"}, 64'({x_ov, x_ir}), 64'(1));
      end
      aux_done[g] = 1'b1;
    end
  end
endmodule
